key_accumulator: RTL and testbench
==================================

Name: key_accumulator

Overview:
- Operand/accumulator stage sitting directly upstream of the board's two-byte hex display decoder.
- Debounces the push-buttons, then latches an 8-bit switch operand on each accepted key press.
- Adds or subtracts that operand into a running 8-bit sum.
- Drives the operand byte (display A pair) and the sum byte (display S pair), plus carry/overflow LEDs.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz; benches use 4).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- sw  input  8  operand switches, sampled only at the update edge
- key_add_n  input  1  add button, active-low, asynchronous to clk
- key_sub_n  input  1  subtract button, active-low, asynchronous to clk
- key_clr_n  input  1  clear button, active-low, asynchronous to clk
- hex_in_A  output  8  last latched operand, to display decoder
- hex_in_S  output  8  running sum modulo 256, to display decoder
- carry  output  1  carry out of last add / borrow of last subtract
- ovf  output  1  two's-complement overflow of last operation
- busy  output  1  high while waiting for all keys to release

Behaviour:
- Reset (async, rst=1): hex_in_A=0, hex_in_S=0, carry=0, ovf=0, busy=0; synchronizers cleared; debounced levels=released; counters=0; FSM=IDLE.
- Reset asserted mid-operation overrides everything immediately. After release, a key still held is seen as a fresh press once debounced.
- Synchronizer: each key passes through a 2-flop synchronizer, inverted to active-high.
- Debounce, per key:
  - Counter counts while synced level != debounced level; it resets to 0 on any cycle they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never flips the level.
- Press pulse: one-cycle pulse on a debounced released->pressed transition only.
- FSM states: IDLE, WAIT_REL.
  - IDLE with any press pulse: update registers at that edge, go to WAIT_REL.
  - WAIT_REL: busy=1; ignore all press pulses; go to IDLE on the first cycle all three debounced levels read released.
  - busy is registered: high the cycle after the update, low the cycle after return to IDLE.
- Simultaneous pulses in the same cycle: priority clr > add > sub; only one operation executes.
- Update, clr: hex_in_S=0, hex_in_A=0, carry=0, ovf=0.
- Update, add: hex_in_A=sw; {carry,hex_in_S} = 9-bit hex_in_S+sw; ovf=1 when both operands share a sign bit and the result sign differs.
- Update, sub: hex_in_A=sw; hex_in_S = hex_in_S-sw mod 256; carry=1 when old hex_in_S < sw (unsigned borrow); ovf=1 when operand signs differ and the result sign differs from old hex_in_S sign.
- Wrap-around: sum is strictly modulo 256, with no saturation.
- Latency: raw key edge to output update = 2 (sync) + DEBOUNCE_CYCLES cycles, ±1 for the async sampling edge.
- sw changes outside the update edge have no effect. All outputs are registered, with no combinational path from inputs.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then clean add: sw=0x25, key_add_n low for 20 cycles, then high -> exactly one update: hex_in_A=0x25, hex_in_S=0x25, carry=0, ovf=0; busy high until release is debounced.
- Bounce rejection: key_add_n toggles every 2 cycles for 30 cycles, then held low -> exactly one add. A 3-cycle low glitch alone -> no update.
- Add wrap and overflow: S=0x7F, sw=0x01 add -> S=0x80, carry=0, ovf=1. Then sw=0x80 add -> S=0x00, carry=1, ovf=1.
- Subtract borrow: S=0x05, sw=0x0A sub -> S=0xFB, carry=1, ovf=0. S=0x80, sw=0x01 sub -> S=0x7F, ovf=1.
- Simultaneous/held keys: add and clr pressed in the same cycle -> clear only, S=0x00. While still holding add, press sub -> no update until both are released and sub is pressed again.
- Async reset mid-debounce: rst pulsed 1 cycle while key_sub_n is low, counter=2 -> all outputs 0 at once. Key still held -> one sub executes DEBOUNCE_CYCLES+2 cycles after rst falls.

Source files
------------

// File: rtl/key_accumulator_if.sv
// Bus bundle for the key accumulator: switch/button inputs toward the
// block and the display/LED outputs back from it.
`timescale 1ns/1ps
interface key_accumulator_if;
  logic [7:0] sw;
  logic       key_add_n;
  logic       key_sub_n;
  logic       key_clr_n;
  logic [7:0] hex_in_A;
  logic [7:0] hex_in_S;
  logic       carry;
  logic       ovf;
  logic       busy;
  logic       dbg_state;

  // master: board side (drives switches/buttons, reads displays)
  modport master (
    output sw, key_add_n, key_sub_n, key_clr_n,
    input  hex_in_A, hex_in_S, carry, ovf, busy, dbg_state
  );

  // slave: the accumulator itself
  modport slave (
    input  sw, key_add_n, key_sub_n, key_clr_n,
    output hex_in_A, hex_in_S, carry, ovf, busy, dbg_state
  );
endinterface

// File: rtl/key_accumulator.sv
// Key accumulator: synchronizes and debounces three active-low buttons,
// then adds/subtracts/clears an 8-bit switch operand into a running sum.
//
// Interaction model (no valid/ready here): an operation is accepted only in
// IDLE on a debounced press pulse; the block then raises busy and ignores
// every further press until all three buttons read released. Outputs are
// plain registers that hold their value between accepted operations.
// dbg_state exposes the FSM state (0 = IDLE, 1 = WAIT_REL).
`timescale 1ns/1ps
module key_accumulator #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic           clk,
  input logic           rst,
  key_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, WAIT_REL = 1'b1} state_t;

  // Key index: 0 = add, 1 = sub, 2 = clr (all active-high after inversion)
  logic [2:0]       raw;
  logic [2:0]       sync1, sync2;
  logic [2:0]       db;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       flip;
  logic [2:0]       press;

  state_t state, state_next;
  logic   do_clr, do_add, do_sub;

  logic [7:0] a_q, s_q;
  logic       carry_q, ovf_q, busy_q;
  logic [8:0] sum9, dif9;

  assign raw = {~bus.key_clr_n, ~bus.key_sub_n, ~bus.key_add_n};

  // Two-flop synchronizer for each button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Flip and press detection: the level flips on the last differing count,
  // and a press pulse fires on the same edge for a released->pressed flip
  always_comb begin
    flip  = '0;
    press = '0;
    for (int i = 0; i < 3; i++) begin
      flip[i]  = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
      press[i] = flip[i] && !db[i];
    end
  end

  // Debounce counters and debounced levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          cnt[i] <= '0;
          db[i]  <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: leave IDLE on any press, return once everything is released
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (|press) state_next = WAIT_REL;
      WAIT_REL: if (db == 3'b000) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs: select the single operation, clr > add > sub
  always_comb begin
    do_clr = 1'b0;
    do_add = 1'b0;
    do_sub = 1'b0;
    if (state == IDLE) begin
      if (press[2])      do_clr = 1'b1;
      else if (press[0]) do_add = 1'b1;
      else if (press[1]) do_sub = 1'b1;
    end
  end

  // Arithmetic on the old sum; bit 8 is carry for add, borrow for subtract
  always_comb begin
    sum9 = {1'b0, s_q} + {1'b0, bus.sw};
    dif9 = {1'b0, s_q} - {1'b0, bus.sw};
  end

  // Operand, sum and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (do_clr) begin
      a_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (do_add) begin
      a_q     <= bus.sw;
      s_q     <= sum9[7:0];
      carry_q <= sum9[8];
      ovf_q   <= (s_q[7] == bus.sw[7]) && (sum9[7] != s_q[7]);
    end else if (do_sub) begin
      a_q     <= bus.sw;
      s_q     <= dif9[7:0];
      carry_q <= dif9[8];
      ovf_q   <= (s_q[7] != bus.sw[7]) && (dif9[7] != s_q[7]);
    end
  end

  // Registered busy flag tracking the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (state_next == WAIT_REL);
  end

  assign bus.hex_in_A  = a_q;
  assign bus.hex_in_S  = s_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_key_accumulator.sv
// Bench for key_accumulator with DEBOUNCE_CYCLES = 4. Expected results are
// hand-computed and queued as {A, S, carry, ovf}; a monitor pops one entry
// on every rising edge of busy (busy rises once per accepted operation).
`timescale 1ns/1ps
module tb_key_accumulator;

  logic clk;
  logic rst;
  key_accumulator_if bus ();

  key_accumulator #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] last_exp = '0;
  logic        busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [17:0] outs();
    return {bus.hex_in_A, bus.hex_in_S, bus.carry, bus.ovf};
  endfunction

  task automatic push(input logic [7:0] a, input logic [7:0] s, input logic c, input logic o);
    exp_q.push_back({a, s, c, o});
    last_exp = {a, s, c, o};
  endtask

  // Monitor: one queued expectation per busy rising edge
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (bus.busy && !busy_prev) begin
        if (exp_q.size() == 0) chk("unexpected_update", {14'd0, outs()}, 32'hFFFF_FFFF);
        else chk("update", {14'd0, outs()}, {14'd0, exp_q.pop_front()});
      end
      busy_prev = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int key, input logic lvl);
    case (key)
      0:       bus.key_add_n = lvl;
      1:       bus.key_sub_n = lvl;
      default: bus.key_clr_n = lvl;
    endcase
  endtask

  // Press a key with operand v; sw is scrambled after the update edge so a
  // late resample of sw would show up in the held outputs
  task automatic press(input int key, input logic [7:0] v, input int hold);
    bus.sw = v;
    set_key(key, 1'b0);
    tick(8);
    bus.sw = ~v;
    tick(hold - 8);
    set_key(key, 1'b1);
    tick(12);
  endtask

  task automatic check_hold(input string name);
    chk(name, {14'd0, outs()}, {14'd0, last_exp});
  endtask

  task automatic check_drained(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int lat;

  initial begin
    rst = 1'b1;
    bus.sw = 8'h00;
    bus.key_add_n = 1'b1;
    bus.key_sub_n = 1'b1;
    bus.key_clr_n = 1'b1;
    tick(3);
    chk("reset_outputs", {14'd0, outs()}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_state", {31'd0, bus.dbg_state}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Clean add, 20-cycle press
    push(8'h25, 8'h25, 1'b0, 1'b0);
    bus.sw = 8'h25;
    bus.key_add_n = 1'b0;
    tick(15);
    chk("busy_while_held", {31'd0, bus.busy}, 32'd1);
    chk("state_while_held", {31'd0, bus.dbg_state}, 32'd1);
    tick(5);
    bus.key_add_n = 1'b1;
    tick(12);
    chk("busy_after_release", {31'd0, bus.busy}, 32'd0);
    check_drained("drained_clean_add");

    // Bouncing add: 2-cycle toggles never qualify, then a solid hold
    push(8'h10, 8'h35, 1'b0, 1'b0);
    bus.sw = 8'h10;
    for (int i = 0; i < 15; i++) begin
      bus.key_add_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    press(0, 8'h10, 20);
    check_drained("drained_bounce");
    check_hold("hold_after_bounce");

    // 3-cycle glitch alone: no update
    bus.sw = 8'h55;
    bus.key_add_n = 1'b0;
    tick(3);
    bus.key_add_n = 1'b1;
    tick(12);
    check_hold("glitch_rejected");

    // Add wrap and overflow
    push(8'h00, 8'h00, 1'b0, 1'b0);
    press(2, 8'h99, 14);
    push(8'h7F, 8'h7F, 1'b0, 1'b0);
    press(0, 8'h7F, 14);
    push(8'h01, 8'h80, 1'b0, 1'b1);
    press(0, 8'h01, 14);
    push(8'h80, 8'h00, 1'b1, 1'b1);
    press(0, 8'h80, 14);
    check_drained("drained_add_wrap");

    // Subtract borrow and overflow
    push(8'h05, 8'h05, 1'b0, 1'b0);
    press(0, 8'h05, 14);
    push(8'h0A, 8'hFB, 1'b1, 1'b0);
    press(1, 8'h0A, 14);
    push(8'h00, 8'h00, 1'b0, 1'b0);
    press(2, 8'h00, 14);
    push(8'h80, 8'h80, 1'b0, 1'b0);
    press(0, 8'h80, 14);
    push(8'h01, 8'h7F, 1'b0, 1'b1);
    press(1, 8'h01, 14);
    check_drained("drained_sub");

    // Add and clr in the same cycle: clear wins
    push(8'h00, 8'h00, 1'b0, 1'b0);
    bus.sw = 8'h11;
    bus.key_add_n = 1'b0;
    bus.key_clr_n = 1'b0;
    tick(10);
    bus.key_clr_n = 1'b1;
    tick(8);
    // sub pressed while add still held: ignored
    bus.sw = 8'h22;
    bus.key_sub_n = 1'b0;
    tick(12);
    bus.key_sub_n = 1'b1;
    tick(10);
    check_hold("sub_ignored_while_held");
    chk("busy_add_still_held", {31'd0, bus.busy}, 32'd1);
    bus.key_add_n = 1'b1;
    tick(12);
    chk("busy_all_released", {31'd0, bus.busy}, 32'd0);
    check_hold("no_update_on_release");
    push(8'h22, 8'hDE, 1'b1, 1'b0);
    press(1, 8'h22, 14);
    check_drained("drained_simultaneous");

    // Async reset mid-debounce with sub held (counter at 2)
    bus.sw = 8'h03;
    bus.key_sub_n = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {14'd0, outs()}, 32'd0);
    chk("async_reset_busy", {31'd0, bus.busy}, 32'd0);
    push(8'h03, 8'hFD, 1'b1, 1'b0);
    tick(1);
    rst = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.hex_in_S != 8'h00) begin
        lat = k;
        break;
      end
    end
    chk("post_reset_latency", lat, 6);
    tick(10);
    bus.key_sub_n = 1'b1;
    tick(12);
    check_drained("drained_reset");
    check_hold("final_hold");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
